// File: rtl/rx_frame_drain_pkg.sv
// Shared definitions for the receive-side drain controller: state encoding,
// frame-info field layout and descriptor helpers.
package rx_frame_drain_pkg;

    localparam int unsigned FRAME_INFO_W = 28;
    localparam int unsigned COUNT_LSB    = 0;
    localparam int unsigned COUNT_MSB    = 7;
    localparam int unsigned STAMP_LSB    = 8;
    localparam int unsigned STAMP_MSB    = 27;
    localparam int unsigned STAMP_W      = STAMP_MSB - STAMP_LSB + 1;
    localparam int unsigned REMAIN_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INFO_CAP,
        ST_BYTE_WAIT,
        ST_BYTE_CAP,
        ST_PRESENT,
        ST_ABORT
    } state_e;

    // A descriptor count of zero encodes a full 256-byte frame.
    function automatic logic [REMAIN_W-1:0] count_to_remain(input logic [7:0] count);
        return (count == 8'd0) ? 9'd256 : {1'b0, count};
    endfunction

endpackage

// File: rtl/rx_drain_timer.sv
// Baud-tick timeout counter: clearable, counts enabled ticks, flags when the
// count reaches a non-zero limit (a zero limit never expires).
module rx_drain_timer #(
    parameter int unsigned TO_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                tick_i,
    input  logic [TO_WIDTH-1:0] limit_i,
    output logic                expired_o
);

    logic [TO_WIDTH-1:0] count_q;
    logic [TO_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (limit_i != '0) && (count_q >= limit_i);

endmodule

// File: rtl/rx_frame_drain.sv
// Drains one frame descriptor and its bytes from the receive FIFOs and
// presents the bytes on a valid/ready stream with first/last/stamp tags.
module rx_frame_drain
    import rx_frame_drain_pkg::*;
#(
    parameter int unsigned TO_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    BaudSig_i,
    input  logic [TO_WIDTH-1:0]     timeout_i,
    input  logic [FRAME_INFO_W-1:0] frame_info_i,
    input  logic                    frame_empty_i,
    output logic                    n_rd_frame_o,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_empty_i,
    output logic                    n_rd_o,
    output logic [7:0]              out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_first_o,
    output logic                    out_last_o,
    output logic [STAMP_W-1:0]      out_stamp_o,
    output logic                    frame_abort_o,
    output logic [7:0]              abort_cnt_o,
    output logic                    busy_o
);

    state_e              state_q, state_d;
    logic [REMAIN_W-1:0] remain_q, remain_d;
    logic                first_flag_q, first_flag_d;
    logic [7:0]          data_q, data_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic [STAMP_W-1:0]  stamp_q, stamp_d;
    logic [7:0]          abort_cnt_q, abort_cnt_d;

    logic rd_frame_n;
    logic rd_byte_n;
    logic timer_clear;
    logic timer_tick;
    logic timer_expired;

    rx_drain_timer #(
        .TO_WIDTH (TO_WIDTH)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clear),
        .tick_i    (timer_tick),
        .limit_i   (timeout_i),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        first_flag_d = first_flag_q;
        data_d       = data_q;
        first_d      = first_q;
        last_d       = last_q;
        stamp_d      = stamp_q;
        abort_cnt_d  = abort_cnt_q;
        rd_frame_n   = 1'b1;
        rd_byte_n    = 1'b1;
        timer_clear  = 1'b0;
        timer_tick   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i && !frame_empty_i) begin
                    rd_frame_n = 1'b0;
                    state_d    = ST_INFO_CAP;
                end
            end
            ST_INFO_CAP: begin
                remain_d     = count_to_remain(frame_info_i[COUNT_MSB:COUNT_LSB]);
                stamp_d      = frame_info_i[STAMP_MSB:STAMP_LSB];
                first_flag_d = 1'b1;
                timer_clear  = 1'b1;
                state_d      = ST_BYTE_WAIT;
            end
            ST_BYTE_WAIT: begin
                // An arriving byte takes priority over a coincident baud tick.
                if (!rx_empty_i) begin
                    rd_byte_n = 1'b0;
                    state_d   = ST_BYTE_CAP;
                end else begin
                    timer_tick = BaudSig_i;
                    if (timer_expired) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_BYTE_CAP: begin
                data_d  = rx_data_i;
                first_d = first_flag_q;
                last_d  = (remain_q == 9'd1);
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready_i) begin
                    remain_d     = remain_q - 9'd1;
                    first_flag_d = 1'b0;
                    timer_clear  = 1'b1;
                    state_d      = (remain_q == 9'd1) ? ST_IDLE : ST_BYTE_WAIT;
                end
            end
            ST_ABORT: begin
                if (abort_cnt_q != '1) begin
                    abort_cnt_d = abort_cnt_q + 8'd1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            first_flag_q <= 1'b0;
            data_q       <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            stamp_q      <= '0;
            abort_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            first_flag_q <= first_flag_d;
            data_q       <= data_d;
            first_q      <= first_d;
            last_q       <= last_d;
            stamp_q      <= stamp_d;
            abort_cnt_q  <= abort_cnt_d;
        end
    end

    // Strobes are combinational; holding them high under reset keeps a
    // mid-frame reset from popping anything.
    assign n_rd_frame_o  = rd_frame_n | rst;
    assign n_rd_o        = rd_byte_n | rst;
    assign out_valid_o   = (state_q == ST_PRESENT);
    assign out_data_o    = data_q;
    assign out_first_o   = first_q;
    assign out_last_o    = last_q;
    assign out_stamp_o   = stamp_q;
    assign frame_abort_o = (state_q == ST_ABORT);
    assign abort_cnt_o   = abort_cnt_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_frame_drain.sv
// Directed bench for rx_frame_drain with behavioural models of both
// one-cycle-latency FIFOs driven from the single stimulus process.
module tb_rx_frame_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        BaudSig_i;
    logic [15:0] timeout_i;
    logic [27:0] frame_info_i;
    logic        frame_empty_i;
    logic        n_rd_frame_o;
    logic [7:0]  rx_data_i;
    logic        rx_empty_i;
    logic        n_rd_o;
    logic [7:0]  out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_first_o;
    logic        out_last_o;
    logic [19:0] out_stamp_o;
    logic        frame_abort_o;
    logic [7:0]  abort_cnt_o;
    logic        busy_o;

    rx_frame_drain #(
        .TO_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .BaudSig_i     (BaudSig_i),
        .timeout_i     (timeout_i),
        .frame_info_i  (frame_info_i),
        .frame_empty_i (frame_empty_i),
        .n_rd_frame_o  (n_rd_frame_o),
        .rx_data_i     (rx_data_i),
        .rx_empty_i    (rx_empty_i),
        .n_rd_o        (n_rd_o),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_first_o   (out_first_o),
        .out_last_o    (out_last_o),
        .out_stamp_o   (out_stamp_o),
        .frame_abort_o (frame_abort_o),
        .abort_cnt_o   (abort_cnt_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [27:0] fq[$];
    logic [7:0]  bq[$];
    logic [7:0]  bd[$];
    logic        bf[$];
    logic        bl[$];
    logic [19:0] bs[$];

    int cyc = 0;
    int frame_strobes = 0;
    int byte_strobes = 0;
    int empty_violations = 0;
    int aborts = 0;
    int first_frame_cyc = -1;
    int first_byte_cyc = -1;
    int first_valid_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, sample strobes/outputs before the edge, then model FIFO pops.
    task automatic step();
        logic rdf, rdb;
        frame_empty_i = (fq.size() == 0);
        rx_empty_i    = (bq.size() == 0);
        #1;
        cyc++;
        rdf = !n_rd_frame_o;
        rdb = !n_rd_o;
        if (rdf) begin
            frame_strobes++;
            if (first_frame_cyc < 0) first_frame_cyc = cyc;
            if (fq.size() == 0) empty_violations++;
        end
        if (rdb) begin
            byte_strobes++;
            if (first_byte_cyc < 0) first_byte_cyc = cyc;
            if (bq.size() == 0) empty_violations++;
        end
        if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid_o && out_ready_i) begin
            bd.push_back(out_data_o);
            bf.push_back(out_first_o);
            bl.push_back(out_last_o);
            bs.push_back(out_stamp_o);
        end
        if (frame_abort_o) aborts++;
        @(posedge clk);
        #1;
        if (rdf && fq.size() != 0) frame_info_i = fq.pop_front();
        if (rdb && bq.size() != 0) rx_data_i = bq.pop_front();
        frame_empty_i = (fq.size() == 0);
        rx_empty_i    = (bq.size() == 0);
    endtask

    task automatic clear_logs();
        bd.delete(); bf.delete(); bl.delete(); bs.delete();
        frame_strobes = 0;
        byte_strobes = 0;
        first_frame_cyc = -1;
        first_byte_cyc = -1;
        first_valid_cyc = -1;
    endtask

    task automatic run_frame(input int beats, input int bound);
        int k = 0;
        while ((bd.size() < beats || busy_o) && k < bound) begin
            step();
            k++;
        end
    endtask

    initial begin
        logic [7:0] snap_d;
        logic       snap_f, snap_l;
        int         nfirst, nlast, bad;
        int         k;

        rst = 1'b1; enable_i = 1'b1; BaudSig_i = 1'b0; timeout_i = 16'd0;
        frame_info_i = '0; rx_data_i = '0; out_ready_i = 1'b1;
        frame_empty_i = 1'b1; rx_empty_i = 1'b1;
        repeat (3) step();

        check("rst_n_rd_frame", n_rd_frame_o, 1);
        check("rst_n_rd", n_rd_o, 1);
        check("rst_valid", out_valid_o, 0);
        check("rst_first_last", {out_first_o, out_last_o}, 0);
        check("rst_data", out_data_o, 0);
        check("rst_stamp", out_stamp_o, 0);
        check("rst_abort", {frame_abort_o, abort_cnt_o}, 0);
        check("rst_busy", busy_o, 0);
        rst = 1'b0;
        step();

        // Three-byte frame, ready held high.
        clear_logs();
        bq.push_back(8'hA1); bq.push_back(8'hA2); bq.push_back(8'hA3);
        fq.push_back({20'hABCDE, 8'd3});
        run_frame(3, 60);
        check("t1_beats", bd.size(), 3);
        check("t1_b0", {bf[0], bl[0], bd[0]}, {2'b10, 8'hA1});
        check("t1_b1", {bf[1], bl[1], bd[1]}, {2'b00, 8'hA2});
        check("t1_b2", {bf[2], bl[2], bd[2]}, {2'b01, 8'hA3});
        check("t1_stamp", (bs[0] == 20'hABCDE) && (bs[1] == 20'hABCDE) && (bs[2] == 20'hABCDE), 1);
        check("t1_byte_strobes", byte_strobes, 3);
        check("t1_frame_strobes", frame_strobes, 1);
        check("t1_info_to_rd_lat", first_byte_cyc - first_frame_cyc, 2);
        check("t1_rd_to_valid_lat", first_valid_cyc - first_byte_cyc, 2);
        check("t1_busy", busy_o, 0);

        // Same frame with a 5-cycle stall on every byte.
        clear_logs();
        out_ready_i = 1'b0;
        bq.push_back(8'hA1); bq.push_back(8'hA2); bq.push_back(8'hA3);
        fq.push_back({20'h13579, 8'd3});
        for (int b = 0; b < 3; b++) begin
            k = 0;
            while (!out_valid_o && k < 20) begin step(); k++; end
            snap_d = out_data_o; snap_f = out_first_o; snap_l = out_last_o;
            check("t2_snap", {snap_f, snap_l, snap_d}, {(b == 0), (b == 2), 8'hA1 + 8'(b)});
            for (int s = 0; s < 5; s++) step();
            check("t2_hold", {out_valid_o, out_first_o, out_last_o, out_data_o, out_stamp_o},
                  {1'b1, snap_f, snap_l, snap_d, 20'h13579});
            out_ready_i = 1'b1;
            step();
            out_ready_i = 1'b0;
        end
        run_frame(3, 20);
        check("t2_beats", bd.size(), 3);
        check("t2_byte_strobes", byte_strobes, 3);
        out_ready_i = 1'b1;

        // Count 0 means 256 bytes.
        clear_logs();
        for (int i = 0; i < 256; i++) bq.push_back(8'(i));
        fq.push_back({20'h00256, 8'd0});
        run_frame(256, 1200);
        check("t3_beats", bd.size(), 256);
        nfirst = 0; nlast = 0; bad = 0;
        for (int i = 0; i < bd.size(); i++) begin
            if (bf[i]) nfirst++;
            if (bl[i]) nlast++;
            if (bd[i] != 8'(i) || bs[i] != 20'h00256) bad++;
        end
        check("t3_first_cnt", nfirst, 1);
        check("t3_last_cnt", nlast, 1);
        check("t3_last_pos", (bd.size() == 256) ? {31'd0, bl[255]} : 32'd0, 1);
        check("t3_data_bad", bad, 0);

        // Timeout 4: one byte of two supplied, then four baud ticks.
        clear_logs();
        aborts = 0;
        timeout_i = 16'd4;
        bq.push_back(8'h55);
        fq.push_back({20'h44444, 8'd2});
        k = 0;
        while (bd.size() < 1 && k < 30) begin step(); k++; end
        check("t4_first_beat", bd.size(), 1);
        for (int t = 0; t < 3; t++) begin
            BaudSig_i = 1'b1; step(); BaudSig_i = 1'b0; step();
        end
        check("t4_no_abort_3", {aborts[7:0], busy_o}, {8'd0, 1'b1});
        BaudSig_i = 1'b1; step(); BaudSig_i = 1'b0;
        for (int t = 0; t < 10; t++) step();
        check("t4_aborts", aborts, 1);
        check("t4_abort_cnt", abort_cnt_o, 1);
        check("t4_busy", busy_o, 0);
        clear_logs();
        bq.push_back(8'h77);
        fq.push_back({20'h77777, 8'd1});
        run_frame(1, 30);
        check("t4_next_beats", bd.size(), 1);
        check("t4_next_beat", (bd.size() == 1) ? {bf[0], bl[0], bd[0], bs[0]} : 30'd0,
              {2'b11, 8'h77, 20'h77777});

        // Timeout disabled, byte arrives after 1000 ticks.
        clear_logs();
        aborts = 0;
        timeout_i = 16'd0;
        fq.push_back({20'h55555, 8'd1});
        for (int t = 0; t < 1000; t++) begin
            BaudSig_i = 1'b1; step(); BaudSig_i = 1'b0; step();
        end
        check("t5_no_abort", {aborts[7:0], busy_o}, {8'd0, 1'b1});
        bq.push_back(8'h99);
        run_frame(1, 30);
        check("t5_beat", (bd.size() == 1) ? {bd[0], bs[0]} : 28'd0, {8'h99, 20'h55555});
        check("t5_abort_cnt", abort_cnt_o, 1);

        // Reset while presenting, then enable low with a descriptor queued.
        clear_logs();
        out_ready_i = 1'b0;
        bq.push_back(8'hC1); bq.push_back(8'hC2);
        fq.push_back({20'hCCCCC, 8'd2});
        k = 0;
        while (!out_valid_o && k < 20) begin step(); k++; end
        check("t6_in_present", out_valid_o, 1);
        rst = 1'b1;
        step();
        check("t6_rst_outs", {out_valid_o, out_first_o, out_last_o, out_data_o, out_stamp_o,
                              frame_abort_o, abort_cnt_o, busy_o}, '0);
        check("t6_rst_strobes", {n_rd_frame_o, n_rd_o}, 2'b11);
        bq.delete();
        rst = 1'b0;
        enable_i = 1'b0;
        clear_logs();
        fq.push_back({20'hDDDDD, 8'd1});
        for (int t = 0; t < 20; t++) step();
        check("t6_disabled_strobes", frame_strobes + byte_strobes, 0);
        check("t6_disabled_busy", busy_o, 0);
        check("empty_violations", empty_violations, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
